pelican_feeder: RTL

PELICAN_FEEDER -- requirements
Module: pelican_feeder

---
 rtl/pelican_pkg.sv | 22 ++
 rtl/pelican_block_fifo.sv | 52 +++++
 rtl/pelican_feeder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pelican_pkg.sv
// Shared types and sizes for the Pelican MAC feeder: word classes, FSM states,
// block/word widths and message FIFO depth.
package pelican_pkg;
  localparam int BLOCK_W    = 128;
  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    TY_IV  = 2'b00,
    TY_KEY = 2'b01,
    TY_MSG = 2'b10,
    TY_RSV = 2'b11
  } stype_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_IV,
    S_KEY_WAIT,
    S_RUN,
    S_FLUSH
  } state_e;
endpackage

// File: rtl/pelican_block_fifo.sv
// Small message-block FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle, leaving occupancy unchanged.
module pelican_block_fifo
  import pelican_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [BLOCK_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [BLOCK_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [BLOCK_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      cnt_q;
  logic               do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_q];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk)
    if (do_push && !clr_i) mem_q[wr_q] <= push_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/pelican_feeder.sv
// Assembles 32-bit host words into 128-bit IV/key/message blocks and presents
// them to the Pelican MAC on request through a registered din.
module pelican_feeder
  import pelican_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic [1:0]         s_type,
  output logic               load_iv,
  input  logic               load_k,
  input  logic               load_m,
  output logic [BLOCK_W-1:0] din,
  input  logic               done,
  output logic               err
);
  state_e                    state_q;
  stype_e                    cls_q, ty;
  logic [1:0]                cnt_q;
  logic [BLOCK_W-WORD_W-1:0] asm_q;
  logic [BLOCK_W-1:0]        iv_q, key_q, din_q, blk, iv_d, key_d, fifo_head;
  logic key_vld_q, pend_k_q, pend_m_q, load_iv_q, err_q;
  logic rdy, xfer, bad, blk_done, iv_done, key_done, msg_done;
  logic k_go_kw, k_go, m_req, m_go, pop, byp, push, m_err;
  logic fifo_full, fifo_empty;

  assign ty = stype_e'(s_type);

  // Stall only the completing word of a message block that has nowhere to go.
  always_comb begin
    rdy = 1'b0;
    if (state_q == S_IDLE || state_q == S_KEY_WAIT || state_q == S_RUN) rdy = 1'b1;
    if (cnt_q == 2'd3 && cls_q == TY_MSG && fifo_full) rdy = 1'b0;
  end
  assign s_ready = rst & rdy;

  assign xfer     = s_valid & s_ready;
  assign bad      = xfer & ((ty == TY_RSV) | ((cnt_q != 2'd0) & (ty != cls_q)));
  assign blk_done = xfer & ~bad & (cnt_q == 2'd3);
  assign blk      = {asm_q, s_data};
  assign iv_done  = blk_done & (cls_q == TY_IV);
  assign key_done = blk_done & (cls_q == TY_KEY);
  assign msg_done = blk_done & (cls_q == TY_MSG);
  assign iv_d     = iv_done  ? blk : iv_q;
  assign key_d    = key_done ? blk : key_q;

  assign k_go_kw = (state_q == S_KEY_WAIT) & (load_k | pend_k_q) & (key_done | key_vld_q);
  assign k_go    = k_go_kw | ((state_q == S_RUN) & load_k);
  // A rekey wins the din register this cycle; the message request stays pending.
  assign m_req   = (state_q == S_RUN) & (load_m | pend_m_q);
  assign m_go    = m_req & ~load_k;
  assign pop     = m_go & ~fifo_empty;
  assign byp     = m_go & fifo_empty & msg_done;
  assign push    = msg_done & ~byp;
  assign m_err   = load_m & (state_q == S_IDLE || state_q == S_KEY_WAIT);

  pelican_block_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (state_q == S_FLUSH),
    .push_i      (push),
    .push_data_i (blk),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cls_q     <= TY_IV;
      cnt_q     <= '0;
      asm_q     <= '0;
      iv_q      <= '0;
      key_q     <= '0;
      din_q     <= '0;
      key_vld_q <= 1'b0;
      pend_k_q  <= 1'b0;
      pend_m_q  <= 1'b0;
      load_iv_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      load_iv_q <= 1'b0;
      if (xfer) begin
        if (bad) begin
          err_q <= 1'b1;
          cnt_q <= '0;
        end else begin
          if (cnt_q == 2'd0) cls_q <= ty;
          if (cnt_q != 2'd3) asm_q <= {asm_q[BLOCK_W-2*WORD_W-1:0], s_data};
          cnt_q <= cnt_q + 2'd1;
        end
      end
      iv_q  <= iv_d;
      key_q <= key_d;
      if (key_done) key_vld_q <= 1'b1;
      if (m_err)    err_q     <= 1'b1;
      if (k_go)     din_q     <= key_d;
      if (pop)      din_q     <= fifo_head;
      if (byp)      din_q     <= blk;
      if (m_req)    pend_m_q  <= ~(pop | byp);
      if (state_q == S_KEY_WAIT) begin
        if (k_go_kw)     pend_k_q <= 1'b0;
        else if (load_k) pend_k_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: if (iv_done) begin
          state_q   <= S_SEND_IV;
          load_iv_q <= 1'b1;
          din_q     <= iv_d;
        end
        S_SEND_IV:  state_q <= S_KEY_WAIT;
        S_KEY_WAIT: if (k_go_kw) state_q <= S_RUN;
        S_RUN:      ;
        S_FLUSH: begin
          state_q   <= S_IDLE;
          pend_m_q  <= 1'b0;
          pend_k_q  <= 1'b0;
          key_vld_q <= 1'b0;
        end
        default:    state_q <= S_IDLE;
      endcase
      if (done && state_q != S_IDLE && state_q != S_FLUSH) state_q <= S_FLUSH;
    end
  end

  assign load_iv = load_iv_q;
  assign din     = din_q;
  assign err     = err_q;
endmodule
